// File: rtl/alu_seq.sv
// alu_seq -- sequential 16x16 unsigned multiplier (shift-add, one step per
// cycle) with an optional 16/16 unsigned restoring divider. Every iteration
// issues exactly one operation to a shared, purely combinational 16-bit ALU
// that lives outside this block (alu_func/alu_a/alu_b out, alu_r/alu_c in).
//
// Build option: ALU_SEQ_DIV_EN
//   defined   -> op selects MUL (0) or DIV (1); a zero divisor finishes early
//                with dbz=1, quotient 16'hFFFF and remainder = dividend.
//   undefined -> op is ignored, every request is a MUL, dbz is constant 0 and
//                no divider logic is built.
//
// Timing: start sampled in cycle 0 -> busy in cycles 1..16 (RUN) -> done in
// cycle 17 (DONE). A zero-divisor DIV spends one RUN cycle and is done in
// cycle 2.
module alu_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  output logic        busy,
  output logic        done,
  output logic [15:0] res_hi,
  output logic [15:0] res_lo,
  output logic        dbz,
  output logic [2:0]  alu_func,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_r,
  input  logic        alu_c
);

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [3:0] LAST_ITER = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;    // iteration index within RUN
  logic [15:0] r_hi;     // MUL: partial product high / DIV: partial remainder
  logic [15:0] r_lo;     // MUL: multiplier shifting out, product low in / DIV: dividend out, quotient in
  logic [15:0] r_m;      // MUL: multiplicand / DIV: divisor
  logic        r_busy;
  logic        r_done;

  logic        w_req_div;   // the request being accepted is a DIV
  logic [15:0] w_mul_hi;
  logic [15:0] w_mul_lo;
  logic [15:0] w_hi_nxt;
  logic [15:0] w_lo_nxt;

`ifdef ALU_SEQ_DIV_EN
  logic        r_op;        // latched op: 1 = DIV
  logic        r_dbz;
  logic        w_quo_bit;   // divisor fits into the shifted partial remainder
  logic [15:0] w_div_hi;
  logic [15:0] w_div_lo;

  assign w_req_div = op;
  assign dbz       = r_dbz;
`else
  logic        w_unused_op;

  // op has no effect in a multiply-only build
  assign w_unused_op = op;
  assign w_req_div   = 1'b0;
  assign dbz         = 1'b0;
`endif

  assign busy   = r_busy;
  assign done   = r_done;
  assign res_hi = r_hi;
  assign res_lo = r_lo;

  // ALU request: one operation per RUN cycle, parked at ADD 0+0 otherwise
  always_comb begin
    // NOTE: every output gets a default first so no path through the block can infer a latch.
    alu_func = ALU_ADD;
    alu_a    = 16'h0000;
    alu_b    = 16'h0000;
    if (r_state == S_RUN) begin
      alu_b = r_m;
`ifdef ALU_SEQ_DIV_EN
      if (r_op) begin
        alu_func = ALU_SUB;
        alu_a    = {r_hi[14:0], r_lo[15]};
      end else begin
        alu_a    = r_hi;
      end
`else
      alu_a = r_hi;
`endif
    end
  end

  // Multiply step: keep hi+m when the multiplier LSB is set, then shift
  // {carry, hi, lo} right by one
  always_comb begin
    if (r_lo[0]) begin
      {w_mul_hi, w_mul_lo} = {alu_c, alu_r, r_lo[15:1]};
    end else begin
      {w_mul_hi, w_mul_lo} = {1'b0, r_hi, r_lo[15:1]};
    end
  end

`ifdef ALU_SEQ_DIV_EN
  // Divide step (restoring): shift the next dividend bit into the remainder,
  // keep the difference when the divisor fits, and shift the quotient bit in.
  // A set hi[15] means the shifted remainder overflowed 16 bits, so it fits
  // regardless of the borrow.
  always_comb begin
    w_quo_bit = r_hi[15] | ~alu_c;
    w_div_hi  = w_quo_bit ? alu_r : alu_a;
    w_div_lo  = {r_lo[14:0], w_quo_bit};
  end

  assign w_hi_nxt = r_op ? w_div_hi : w_mul_hi;
  assign w_lo_nxt = r_op ? w_div_lo : w_mul_lo;
`else
  assign w_hi_nxt = w_mul_hi;
  assign w_lo_nxt = w_mul_lo;
`endif

  // Control FSM with registered busy/done and the hi/lo/m datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_hi    <= 16'h0000;
      r_lo    <= 16'h0000;
      r_m     <= 16'h0000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      r_op    <= 1'b0;
      r_dbz   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            // MUL shifts the multiplier (opb) through lo; DIV shifts the dividend (opa)
            r_hi    <= 16'h0000;
            r_lo    <= w_req_div ? opa : opb;
            r_m     <= w_req_div ? opb : opa;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
`ifdef ALU_SEQ_DIV_EN
            r_op    <= op;
            r_dbz   <= 1'b0;
`endif
          end else begin
            // results stay on hi/lo until the next accepted start
            r_state <= S_IDLE;
          end
        end

        S_RUN: begin
`ifdef ALU_SEQ_DIV_EN
          if (r_op && (r_m == 16'h0000)) begin
            // zero divisor: no iterations; remainder reports the dividend,
            // quotient saturates to all ones
            r_hi    <= r_lo;
            r_lo    <= 16'hFFFF;
            r_dbz   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else
`endif
          begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == LAST_ITER) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- self-checking bench for alu_seq. Models the shared ALU
// combinationally, drives a table of directed MUL/DIV vectors, then runs
// hand-written sequences for ignored starts, back-to-back starts from DONE and
// reset during RUN. Expectations follow ALU_SEQ_DIV_EN: without it, op=1
// requests are expected to produce products.
module tb_alu_seq;

`ifdef ALU_SEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [15:0] opa = 16'h0000;
  logic [15:0] opb = 16'h0000;
  logic        busy, done, dbz;
  logic [15:0] res_hi, res_lo;
  logic [2:0]  alu_func;
  logic [15:0] alu_a, alu_b;
  logic [15:0] alu_r;
  logic        alu_c;

  int n_checks = 0;
  int n_err    = 0;

  alu_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .opa      (opa),
    .opb      (opb),
    .busy     (busy),
    .done     (done),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .dbz      (dbz),
    .alu_func (alu_func),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_r    (alu_r),
    .alu_c    (alu_c)
  );

  always #5 clk = ~clk;

  // Shared ALU: ADD gives carry-out, SUB gives borrow
  always_comb begin
    alu_r = 16'h0000;
    alu_c = 1'b0;
    case (alu_func)
      3'b000:  {alu_c, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001:  {alu_c, alu_r} = {1'b0, alu_a} - {1'b0, alu_b};
      default: ;
    endcase
  end

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic o, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] hi, input logic [15:0] lo,
                              input logic z, input int lat);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.dbz = z; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a request for one clock edge; returns at the negedge of cycle 1
  task automatic start_op(input logic o, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    @(negedge clk);
    start = 1'b0; op = ~o; opa = ~a; opb = ~b;
  endtask

  // Bounded wait for done; lat is the cycle number (start cycle = 0)
  task automatic wait_done(output int lat, output int busy_cyc);
    lat = 1;
    busy_cyc = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input vec_t v, input string tag);
    int   lat, bc;
    logic is_div;
    is_div = DIV_EN && v.op;
    start_op(v.op, v.a, v.b);
    check({tag, " run alu_func"}, 32'(alu_func), is_div ? 32'd1 : 32'd0);
    check({tag, " run alu_a"}, 32'(alu_a), is_div ? {31'd0, v.a[15]} : 32'd0);
    check({tag, " run alu_b"}, 32'(alu_b), is_div ? 32'(v.b) : 32'(v.a));
    wait_done(lat, bc);
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " busy cycles"}, 32'(bc), 32'(v.lat - 1));
    check({tag, " busy at done"}, 32'(busy), 32'd0);
    check({tag, " res_hi"}, 32'(res_hi), 32'(v.hi));
    check({tag, " res_lo"}, 32'(res_lo), 32'(v.lo));
    check({tag, " dbz"}, 32'(dbz), 32'(v.dbz));
    check({tag, " alu idle"}, {13'd0, alu_func, alu_a}, 32'd0);
    @(negedge clk);
    check({tag, " done one cycle"}, 32'(done), 32'd0);
    check({tag, " result hold"}, {res_hi, res_lo}, {v.hi, v.lo});
  endtask

  initial begin
    int          lat, bc, busy_bad, done_cyc, done_cnt;
    logic [15:0] hi_at, lo_at;

    vecs[0] = mk(1'b0, 16'h0003, 16'h0005, 16'h0000, 16'h000F, 1'b0, 17);
    vecs[1] = mk(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 17);
    vecs[2] = mk(1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, 17);
    vecs[3] = mk(1'b0, 16'h1234, 16'h0001, 16'h0000, 16'h1234, 1'b0, 17);
    vecs[4] = mk(1'b0, 16'h8000, 16'h0002, 16'h0001, 16'h0000, 1'b0, 17);
    vecs[5] = mk(1'b0, 16'hABCD, 16'h1234, 16'h0C37, 16'h4FA4, 1'b0, 17);
`ifdef ALU_SEQ_DIV_EN
    vecs[6]  = mk(1'b1, 16'd100,  16'd7,    16'd2,    16'd14,   1'b0, 17);
    vecs[7]  = mk(1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 17);
    vecs[8]  = mk(1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 2);
    vecs[9]  = mk(1'b1, 16'h1234, 16'h1234, 16'h0000, 16'h0001, 1'b0, 17);
    vecs[10] = mk(1'b1, 16'h0005, 16'h0009, 16'h0005, 16'h0000, 1'b0, 17);
`else
    vecs[6]  = mk(1'b1, 16'd100,  16'd7,    16'h0000, 16'h02BC, 1'b0, 17);
    vecs[7]  = mk(1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 17);
    vecs[8]  = mk(1'b1, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0, 17);
    vecs[9]  = mk(1'b1, 16'h1234, 16'h1234, 16'h014B, 16'h5A90, 1'b0, 17);
    vecs[10] = mk(1'b1, 16'h0005, 16'h0009, 16'h0000, 16'h002D, 1'b0, 17);
`endif

    // Reset state
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset res_hi", 32'(res_hi), 32'd0);
    check("reset res_lo", 32'(res_lo), 32'd0);
    check("reset dbz", 32'(dbz), 32'd0);
    check("reset alu", {13'd0, alu_func, alu_a}, 32'd0);
    check("reset alu_b", 32'(alu_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < NVEC; i++) begin
      do_op(vecs[i], $sformatf("vec%0d", i));
    end

    // A start while busy is ignored and its operands are not sampled
    start_op(1'b0, 16'h0003, 16'h0005);
    busy_bad = 0; done_cyc = 0; hi_at = 16'h0000; lo_at = 16'h0000;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (busy !== ((cyc <= 16) ? 1'b1 : 1'b0)) busy_bad++;
      if (done === 1'b1 && done_cyc == 0) begin
        done_cyc = cyc; hi_at = res_hi; lo_at = res_lo;
      end
      if (cyc == 5) begin start = 1'b1; op = 1'b0; opa = 16'h0007; opb = 16'h0007; end
      if (cyc == 6) start = 1'b0;
      @(negedge clk);
    end
    check("ignored start busy profile", 32'(busy_bad), 32'd0);
    check("ignored start done cycle", 32'(done_cyc), 32'd17);
    check("ignored start res_hi", 32'(hi_at), 32'h0000);
    check("ignored start res_lo", 32'(lo_at), 32'h000F);

    // Start accepted in the DONE cycle; dbz clears on the new start
    start_op(1'b1, 16'h1234, 16'h0000);
    wait_done(lat, bc);
    check("b2b first latency", 32'(lat), DIV_EN ? 32'd2 : 32'd17);
    check("b2b first dbz", 32'(dbz), 32'(DIV_EN));
    start = 1'b1; op = 1'b0; opa = 16'h0002; opb = 16'h0009;
    @(negedge clk);
    start = 1'b0;
    check("b2b accepted busy", 32'(busy), 32'd1);
    wait_done(lat, bc);
    check("b2b second latency", 32'(lat), 32'd17);
    check("b2b second result", {res_hi, res_lo}, 32'h0000_0012);
    check("b2b second dbz", 32'(dbz), 32'd0);
    @(negedge clk);

    // Reset during RUN aborts without a done pulse
    start_op(1'b0, 16'h0003, 16'h0005);
    repeat (7) @(negedge clk);
    check("pre-reset busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort result", {res_hi, res_lo}, 32'd0);
    check("abort done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    check("abort no done", 32'(done_cnt), 32'd0);
    do_op(mk(1'b0, 16'h0002, 16'h0002, 16'h0000, 16'h0004, 1'b0, 17), "post-reset mul");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
